// File: rtl/bcd_to_bin_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin_seq_if
// Description : Request/result bundle for the sequential BCD-to-binary
//               converter.
//               master : drives start, bcd_in; observes bin_out, busy, done, err
//               slave  : the converter side of the same signals
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  bin_out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output bin_out,
        output busy,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential packed-BCD to binary converter using reverse
//               double dabble, one bit per clock, BIN_W steps per conversion.
//               A request whose digits are not all 0..9 is rejected at once
//               with err and a single done pulse.
// Ports       : clk     - clock, all state changes on the rising edge
//               reset_p - synchronous active-high reset
//               bus     - slave side of bcd_to_bin_seq_if
//                         (start, bcd_in in; bin_out, busy, done, err out)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  wire                    clk,
    input  wire                    reset_p,
    bcd_to_bin_seq_if.slave        bus
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_TOT_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]          r_state,   w_state_nxt;
    logic [c_BCD_W-1:0]  r_bcd,     w_bcd_nxt;
    logic [BIN_W-1:0]    r_bin,     w_bin_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [BIN_W-1:0]    r_bin_out, w_bin_out_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_err,     w_err_nxt;

    logic [DIGITS-1:0]   w_digit_bad;
    logic [c_TOT_W-1:0]  w_shift;
    logic [c_BCD_W-1:0]  w_bcd_sh;
    logic [BIN_W-1:0]    w_bin_sh;
    logic [c_BCD_W-1:0]  w_bcd_fix;

    // One step: the LSB of the BCD register moves into the top of the binary
    // register, then each digit that now reads 8..15 is brought back into
    // range by subtracting 3 (undoing the halving carry of 10 -> 5 vs 8).
    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[c_TOT_W-1 -: c_BCD_W];
    assign w_bin_sh = w_shift[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_digit_bad[i]     = (bus.bcd_in[4*i +: 4] > 4'd9);
        assign w_bcd_fix[4*i +: 4] = w_bcd_sh[4*i + 3] ? (w_bcd_sh[4*i +: 4] - 4'd3)
                                                       :  w_bcd_sh[4*i +: 4];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bcd_nxt     = r_bcd;
        w_bin_nxt     = r_bin;
        w_cnt_nxt     = r_cnt;
        w_bin_out_nxt = r_bin_out;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (|w_digit_bad) begin
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_bcd_nxt   = bus.bcd_in;
                        w_bin_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_bcd_nxt = w_bcd_fix;
                w_bin_nxt = w_bin_sh;
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_LAST) begin
                    w_bin_out_nxt = w_bin_sh;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state   <= S_IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_bin     <= w_bin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bin_out <= w_bin_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.bin_out = r_bin_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter: DIGITS, 4, number of packed BCD digits on bcd_in.
REQ-002 Parameter: BIN_W, 14, binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1; equals iteration count.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_p  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port: start  input  1  request conversion; sampled each rising edge.
REQ-006 Port: bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled only on accepted start.
REQ-007 Port: bin_out  output  BIN_W  registered binary result of the last valid conversion.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking completion (valid or rejected).
REQ-010 Port: err  output  1  registered; 1 = last accepted request had an invalid digit.

Function
REQ-011 States SHALL be IDLE and SHIFT; no other states.
REQ-012 Start accepted only when state = IDLE and start = 1 at a rising edge (edge T0); start in SHIFT ignored, not queued.
REQ-013 On acceptance, if any digit of bcd_in > 9: err <= 1, done <= 1 for exactly one cycle, state stays IDLE, busy stays 0, bin_out unchanged.
REQ-014 On acceptance with all digits <= 9: err <= 0, bcd shift register <= bcd_in, binary shift register <= 0, iteration counter <= 0, busy <= 1, state <= SHIFT.
REQ-015 Each edge in SHIFT performs one reverse-double-dabble step: shift concatenation {bcd_reg, bin_reg} right by 1; then every 4-bit digit of bcd_reg >= 8 has 3 subtracted (all digits corrected in the same cycle, using post-shift values).
REQ-016 Exactly BIN_W steps, on edges T1..T(BIN_W); counter width SHALL hold BIN_W.
REQ-017 At edge T(BIN_W): bin_out <= final binary value, done <= 1, busy <= 0, state <= IDLE.
REQ-018 Latency: done visible for the single cycle after edge T(BIN_W) (14 clocks after T0 at default); busy high for exactly BIN_W cycles.
REQ-019 done SHALL be 0 in all cycles except those in REQ-013 and REQ-017.
REQ-020 start high at T(BIN_W) SHALL be ignored; start still high at T(BIN_W)+1 SHALL be accepted (back-to-back conversions allowed).
REQ-021 bcd_in changes while busy SHALL not affect the result in progress.
REQ-022 bin_out SHALL change only at REQ-017 or reset; err only at acceptance or reset.
REQ-023 Result SHALL equal the decimal value of bcd_in for all 10^DIGITS valid inputs.

Reset
REQ-024 When reset_p = 1 at a rising edge: state <= IDLE, bin_out <= 0, busy <= 0, done <= 0, err <= 0, internal registers <= 0.
REQ-025 Reset SHALL take priority over start and over an in-progress conversion; aborted conversion produces no done pulse.
REQ-026 start asserted on the same edge as reset_p SHALL be ignored.

Verification
REQ-027 bcd_in = 16'h9999, start 1 cycle -> busy 14 cycles, then done 1 cycle with bin_out = 14'h270F (9999), err = 0.
REQ-028 bcd_in = 16'h0000 -> bin_out = 0 after 14 cycles; bcd_in = 16'h4095 -> bin_out = 14'h0FFF.
REQ-029 After 16'h1234 completes (bin_out = 14'h04D2), bcd_in = 16'h12A4 with start -> done and err = 1 the cycle after T0, busy never high, bin_out stays 14'h04D2.
REQ-030 Start 16'h1234, then start with bcd_in = 16'h0042 at T5 -> ignored; result 14'h04D2 at T14; single done pulse.
REQ-031 Start 16'h5678, reset_p at T7 -> next cycle all outputs 0, no done; later start 16'h0001 -> bin_out = 1 after 14 cycles.
REQ-032 start held high continuously with 16'h0100 -> done every 15 cycles, bin_out = 14'h0064 (100) each time.
